rgmii_rx_adapter: RTL and testbench

RGMII_RX_ADAPTER -- requirements
Module: rgmii_rx_adapter

---
 rtl/rgmii_pkg.sv | 31 +++
 rtl/rgmii_rx_adapter_if.sv | 29 ++
 rtl/rgmii_inband_status.sv | 74 +++++++
 rtl/rgmii_rx_adapter.sv | 136 +++++++++++++
 tb/tb_rgmii_rx_adapter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII receive adapter: GMII speed codes, frame FSM
// states and the in-band status nibble layout.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPD_10     = 2'b00,
        SPD_100    = 2'b01,
        SPD_1G     = 2'b10,
        SPD_1G_ALT = 2'b11
    } speed_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // Bit order matches the interframe rxd[3:0] nibble: {duplex, speed[1:0], link}.
    typedef struct packed {
        logic       full_duplex;
        logic [1:0] speed;
        logic       link_up;
    } inband_status_t;

    localparam logic [3:0] FALSE_CARRIER_CODE = 4'hE;

    function automatic logic is_gig(input logic [1:0] s);
        return (s == 2'(SPD_1G)) || (s == 2'(SPD_1G_ALT));
    endfunction

endpackage

// File: rtl/rgmii_rx_adapter_if.sv
// GMII-side receive bundle plus the byte-wide output and in-band status.
interface rgmii_rx_adapter_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [1:0] speed;

    logic [7:0] out_rxd;
    logic       out_dv;
    logic       out_er;
    logic       out_clk_en;
    logic       link_up;
    logic       full_duplex;
    logic [1:0] link_speed;
    logic       status_change;
    logic       false_carrier;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, speed,
        input  out_rxd, out_dv, out_er, out_clk_en,
        input  link_up, full_duplex, link_speed, status_change, false_carrier
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, speed,
        output out_rxd, out_dv, out_er, out_clk_en,
        output link_up, full_duplex, link_speed, status_change, false_carrier
    );
endinterface

// File: rtl/rgmii_inband_status.sv
// Interframe in-band status decode with a consecutive-sample debounce, plus
// false-carrier detection.
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ENABLE_INBAND   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd,
    input  logic       dv,
    input  logic       er,
    output logic       link_up,
    output logic       full_duplex,
    output logic [1:0] link_speed,
    output logic       status_change,
    output logic       false_carrier
);

    inband_status_t stat;
    logic           chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) false_carrier <= 1'b0;
        else     false_carrier <= !dv && er && (rxd == FALSE_CARRIER_CODE);
    end

    if (ENABLE_INBAND) begin : g_inband
        localparam logic [3:0] DB = 4'(DEBOUNCE_CYCLES);

        inband_status_t sample, cand_q;
        logic [3:0]     cnt_q, cnt_nxt;

        assign sample = inband_status_t'(rxd);

        // A zero count means no candidate yet, so the first sample always restarts at 1.
        always_comb begin
            cnt_nxt = 4'd1;
            if (cnt_q != 4'd0 && sample == cand_q)
                cnt_nxt = (cnt_q == DB) ? cnt_q : cnt_q + 4'd1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cand_q <= '0;
                cnt_q  <= '0;
                stat   <= '0;
                chg    <= 1'b0;
            end else begin
                chg <= 1'b0;
                if (dv) begin
                    cnt_q <= '0;
                end else if (!er) begin
                    cand_q <= sample;
                    cnt_q  <= cnt_nxt;
                    if (cnt_nxt == DB) begin
                        stat <= sample;
                        chg  <= (sample != stat);
                    end
                end
            end
        end
    end else begin : g_no_inband
        assign stat = '0;
        assign chg  = 1'b0;
    end

    assign link_up       = stat.link_up;
    assign full_duplex   = stat.full_duplex;
    assign link_speed    = stat.speed;
    assign status_change = chg;

endmodule

// File: rtl/rgmii_rx_adapter.sv
// GMII receive adapter: passes bytes through at 1G and pairs nibbles into bytes
// at 10/100, with a clock-enable qualifier and in-band status decode.
module rgmii_rx_adapter
    import rgmii_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ENABLE_INBAND   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    rgmii_rx_adapter_if.slave bus
);

    state_e     state, state_nxt;
    logic [1:0] spd_q;
    logic       gig, data_in;
    logic       phase_q, phase_nxt;
    logic [3:0] low_q, low_nxt;
    logic       er_low_q, er_low_nxt;
    logic [7:0] rxd_q, rxd_nxt;
    logic       dv_q, dv_nxt, er_q, er_nxt, ce_q, ce_nxt;

    // The frame keeps the speed seen on its first cycle; everything else follows the live input.
    assign gig     = is_gig((state == ST_FRAME) ? spd_q : bus.speed);
    assign data_in = bus.gmii_rx_dv && (state != ST_DISCARD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_DISCARD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.gmii_rx_dv)  state_nxt = ST_FRAME;
            ST_FRAME:   if (!bus.gmii_rx_dv) state_nxt = ST_IDLE;
            ST_DISCARD: if (!bus.gmii_rx_dv) state_nxt = ST_IDLE;
            default:                         state_nxt = ST_DISCARD;
        endcase
    end

    always_comb begin
        rxd_nxt    = rxd_q;
        dv_nxt     = dv_q;
        er_nxt     = er_q;
        ce_nxt     = 1'b0;
        phase_nxt  = phase_q;
        low_nxt    = low_q;
        er_low_nxt = er_low_q;
        if (gig) begin
            ce_nxt    = 1'b1;
            phase_nxt = 1'b0;
            if (state == ST_DISCARD) begin
                rxd_nxt = '0;
                dv_nxt  = 1'b0;
                er_nxt  = 1'b0;
            end else begin
                rxd_nxt = bus.gmii_rxd;
                dv_nxt  = bus.gmii_rx_dv;
                er_nxt  = bus.gmii_rx_er;
            end
        end else if (data_in) begin
            // The first nibble of a frame is always the low half, whatever the idle phase was.
            if (state == ST_IDLE || !phase_q) begin
                low_nxt    = bus.gmii_rxd[3:0];
                er_low_nxt = bus.gmii_rx_er;
                phase_nxt  = 1'b1;
            end else begin
                rxd_nxt   = {bus.gmii_rxd[3:0], low_q};
                dv_nxt    = 1'b1;
                er_nxt    = bus.gmii_rx_er | er_low_q;
                ce_nxt    = 1'b1;
                phase_nxt = 1'b0;
            end
        end else if (state == ST_FRAME) begin
            phase_nxt = 1'b0;
            if (phase_q) begin
                rxd_nxt = {4'h0, low_q};
                dv_nxt  = 1'b1;
                er_nxt  = 1'b1;
                ce_nxt  = 1'b1;
            end
        end else begin
            phase_nxt = !phase_q;
            if (phase_q) begin
                dv_nxt = 1'b0;
                er_nxt = 1'b0;
                ce_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q    <= '0;
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            ce_q     <= 1'b1;
            phase_q  <= 1'b0;
            low_q    <= '0;
            er_low_q <= 1'b0;
            spd_q    <= '0;
        end else begin
            rxd_q    <= rxd_nxt;
            dv_q     <= dv_nxt;
            er_q     <= er_nxt;
            ce_q     <= ce_nxt;
            phase_q  <= phase_nxt;
            low_q    <= low_nxt;
            er_low_q <= er_low_nxt;
            if (state == ST_IDLE && bus.gmii_rx_dv) spd_q <= bus.speed;
        end
    end

    assign bus.out_rxd    = rxd_q;
    assign bus.out_dv     = dv_q;
    assign bus.out_er     = er_q;
    assign bus.out_clk_en = ce_q;

    rgmii_inband_status #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ENABLE_INBAND   (ENABLE_INBAND)
    ) u_inband (
        .clk           (clk),
        .rst           (rst),
        .rxd           (bus.gmii_rxd[3:0]),
        .dv            (bus.gmii_rx_dv),
        .er            (bus.gmii_rx_er),
        .link_up       (bus.link_up),
        .full_duplex   (bus.full_duplex),
        .link_speed    (bus.link_speed),
        .status_change (bus.status_change),
        .false_carrier (bus.false_carrier)
    );

endmodule

// File: tb/tb_rgmii_rx_adapter.sv
// Directed bench for rgmii_rx_adapter: a vector table for the datapath plus
// hand sequences for in-band status, false carrier and reset corner cases.
module tb_rgmii_rx_adapter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rgmii_rx_adapter_if bus ();

    rgmii_rx_adapter #(.DEBOUNCE_CYCLES(4), .ENABLE_INBAND(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic       er;
        logic [7:0] rxd;
        logic [1:0] spd;
        logic       ce;
        logic       odv;
        logic       oer;
        logic [7:0] orxd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic dv, input logic er, input logic [7:0] rxd,
                                input logic [1:0] spd, input logic ce, input logic odv,
                                input logic oer, input logic [7:0] orxd);
        vec_t v;
        v.dv = dv; v.er = er; v.rxd = rxd; v.spd = spd;
        v.ce = ce; v.odv = odv; v.oer = oer; v.orxd = orxd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic dv, input logic er, input logic [7:0] rxd, input logic [1:0] spd);
        bus.gmii_rx_dv = dv;
        bus.gmii_rx_er = er;
        bus.gmii_rxd   = rxd;
        bus.speed      = spd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string nm, input logic link, input logic dup,
                              input logic [1:0] lspd, input logic chg);
        chk({nm, "_link"}, 8'(bus.link_up), 8'(link));
        chk({nm, "_dup"},  8'(bus.full_duplex), 8'(dup));
        chk({nm, "_lspd"}, 8'(bus.link_speed), 8'(lspd));
        chk({nm, "_chg"},  8'(bus.status_change), 8'(chg));
    endtask

    initial begin
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
        bus.speed      = 2'b10;

        // 1G: registered copy, one speed change mid-frame that must be ignored
        add(0, 0, 8'h00, 2'b10, 1, 0, 0, 8'h00);
        add(1, 0, 8'h55, 2'b10, 1, 1, 0, 8'h55);
        add(1, 0, 8'h55, 2'b10, 1, 1, 0, 8'h55);
        add(1, 0, 8'hD5, 2'b10, 1, 1, 0, 8'hD5);
        add(1, 1, 8'h01, 2'b10, 1, 1, 1, 8'h01);
        add(1, 0, 8'h40, 2'b01, 1, 1, 0, 8'h40);
        add(0, 0, 8'h00, 2'b01, 1, 0, 0, 8'h00);
        // 100M: idle marker, then nibble pairs D5 / 01 / 02 (er on low nibble)
        add(0, 0, 8'h00, 2'b01, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 2'b01, 1, 0, 0, 8'h00);
        add(1, 0, 8'h05, 2'b01, 0, 0, 0, 8'h00);
        add(1, 0, 8'hFD, 2'b01, 1, 1, 0, 8'hD5);
        add(1, 0, 8'h01, 2'b01, 0, 0, 0, 8'h00);
        add(1, 0, 8'h00, 2'b01, 1, 1, 0, 8'h01);
        add(1, 1, 8'h02, 2'b01, 0, 0, 0, 8'h00);
        add(1, 0, 8'h00, 2'b01, 1, 1, 1, 8'h02);
        add(0, 0, 8'h00, 2'b01, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 2'b01, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 2'b01, 1, 0, 0, 8'h02);
        // 10M: seven nibbles -> 21, 43, 65, then 07 flagged as error
        add(1, 0, 8'h01, 2'b00, 0, 0, 0, 8'h00);
        add(1, 0, 8'h02, 2'b00, 1, 1, 0, 8'h21);
        add(1, 0, 8'h03, 2'b00, 0, 0, 0, 8'h00);
        add(1, 0, 8'h04, 2'b00, 1, 1, 0, 8'h43);
        add(1, 0, 8'h05, 2'b00, 0, 0, 0, 8'h00);
        add(1, 0, 8'h06, 2'b00, 1, 1, 0, 8'h65);
        add(1, 0, 8'h07, 2'b00, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 2'b00, 1, 1, 1, 8'h07);
        add(0, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 2'b00, 1, 0, 0, 8'h07);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce",  8'(bus.out_clk_en), 8'h01);
        chk("rst_dv",  8'(bus.out_dv), 8'h00);
        chk("rst_er",  8'(bus.out_er), 8'h00);
        chk("rst_rxd", bus.out_rxd, 8'h00);
        chk("rst_fc",  8'(bus.false_carrier), 8'h00);
        chk_status("rst", 0, 0, 2'b00, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].dv, vq[i].er, vq[i].rxd, vq[i].spd);
            chk($sformatf("v%0d_ce", i), 8'(bus.out_clk_en), 8'(vq[i].ce));
            chk($sformatf("v%0d_fc", i), 8'(bus.false_carrier), 8'h00);
            if (vq[i].ce) begin
                chk($sformatf("v%0d_dv", i),  8'(bus.out_dv), 8'(vq[i].odv));
                chk($sformatf("v%0d_er", i),  8'(bus.out_er), 8'(vq[i].oer));
                chk($sformatf("v%0d_rxd", i), bus.out_rxd, vq[i].orxd);
            end
        end

        // In-band: 4'hD needs four consecutive samples, then a short glitch is ignored
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h0D, 2'b00);
            chk_status($sformatf("ib_pre%0d", k), 0, 0, 2'b00, 0);
        end
        step(0, 0, 8'h0D, 2'b00);
        chk_status("ib_upd", 1, 1, 2'b10, 1);
        step(0, 0, 8'h0D, 2'b00);
        chk_status("ib_hold", 1, 1, 2'b10, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h00, 2'b00);
            chk_status($sformatf("ib_glitch%0d", k), 1, 1, 2'b10, 0);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 8'h0D, 2'b00);
            chk_status($sformatf("ib_same%0d", k), 1, 1, 2'b10, 0);
        end

        // False carrier: pulses each cycle, status untouched
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 8'h0E, 2'b00);
            chk($sformatf("fc_pulse%0d", k), 8'(bus.false_carrier), 8'h01);
            chk_status($sformatf("fc_st%0d", k), 1, 1, 2'b10, 0);
        end
        step(0, 0, 8'h0D, 2'b00);
        chk("fc_end", 8'(bus.false_carrier), 8'h00);

        // An in-frame cycle restarts the debounce count
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h00, 2'b00);
            chk_status($sformatf("clr_a%0d", k), 1, 1, 2'b10, 0);
        end
        step(1, 0, 8'h00, 2'b00);
        chk_status("clr_dv", 1, 1, 2'b10, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h00, 2'b00);
            chk_status($sformatf("clr_b%0d", k), 1, 1, 2'b10, 0);
        end
        step(0, 0, 8'h00, 2'b00);
        chk_status("clr_upd", 0, 0, 2'b00, 1);

        // Reset mid-frame, released while dv is still high
        step(1, 0, 8'hAA, 2'b10);
        chk("rf_dv0",  8'(bus.out_dv), 8'h01);
        chk("rf_rxd0", bus.out_rxd, 8'hAA);
        rst = 1'b1;
        #1;
        chk("rf_async_dv", 8'(bus.out_dv), 8'h00);
        chk("rf_async_ce", 8'(bus.out_clk_en), 8'h01);
        step(1, 0, 8'hBB, 2'b10);
        rst = 1'b0;
        step(1, 0, 8'h77, 2'b10);
        chk("rf_disc_dv0", 8'(bus.out_dv), 8'h00);
        chk("rf_disc_ce0", 8'(bus.out_clk_en), 8'h01);
        step(1, 0, 8'h66, 2'b10);
        chk("rf_disc_dv1", 8'(bus.out_dv), 8'h00);
        step(0, 0, 8'h00, 2'b10);
        chk("rf_disc_dv2", 8'(bus.out_dv), 8'h00);
        step(1, 0, 8'h33, 2'b10);
        chk("rf_new_dv",  8'(bus.out_dv), 8'h01);
        chk("rf_new_rxd", bus.out_rxd, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
